ysyx_22041461_divider: RTL and testbench

Iterative radix-2 integer divider for the RV64M divide/remainder group (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW). It is the multi-cycle responder to the execute stage. Execute issues one operation through a valid/ready request handshake. The divider computes one quotient bit per cycle and returns the 64-bit writeback value through a valid/ready response handshake. RISC-V corner-case results (divide by zero, signed overflow) are produced without iterating.

---
 rtl/ysyx_22041461_divider_if.sv | 28 ++
 rtl/ysyx_22041461_divider.sv | 155 +++++++++++++++
 tb/tb_ysyx_22041461_divider.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_divider_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface ysyx_22041461_divider_if;
  localparam int unsigned XLEN = 64;

  logic            div_valid;
  logic            div_ready;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_signed;
  logic            div_word;
  logic            div_rem;
  logic            div_flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_valid, div_dividend, div_divisor, div_signed, div_word, div_rem,
           div_flush, out_ready,
    input  div_ready, out_valid, div_result
  );

  modport slave (
    input  div_valid, div_dividend, div_divisor, div_signed, div_word, div_rem,
           div_flush, out_ready,
    output div_ready, out_valid, div_result
  );
endinterface

// File: rtl/ysyx_22041461_divider.sv
// Iterative radix-2 restoring divider for the RV64M DIV/REM family, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and resolve straight into DONE.
module ysyx_22041461_divider (
  input  logic                    clk,
  input  logic                    rst_n,
  ysyx_22041461_divider_if.slave  bus
);
  localparam int unsigned XLEN  = 64;
  localparam int unsigned HALF  = 32;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_word;
  logic              r_rem_sel;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;

  // W-form results are always the sign-extended low word.
  function automatic logic [XLEN-1:0] f_wext(input logic word, input logic [XLEN-1:0] v);
    f_wext = word ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_corner_val;
  logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_corner, w_accept, w_resp;

  always_comb begin
    w_a_ext = bus.div_dividend;
    w_b_ext = bus.div_divisor;
    if (bus.div_word) begin
      w_a_ext = bus.div_signed ? {{HALF{bus.div_dividend[HALF-1]}}, bus.div_dividend[HALF-1:0]}
                               : {{HALF{1'b0}}, bus.div_dividend[HALF-1:0]};
      w_b_ext = bus.div_signed ? {{HALF{bus.div_divisor[HALF-1]}}, bus.div_divisor[HALF-1:0]}
                               : {{HALF{1'b0}}, bus.div_divisor[HALF-1:0]};
    end
    w_a_neg  = bus.div_signed & w_a_ext[XLEN-1];
    w_b_neg  = bus.div_signed & w_b_ext[XLEN-1];
    w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
    w_min    = bus.div_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    w_div0   = (w_b_ext == '0);
    w_ovf    = bus.div_signed & (w_b_ext == '1) & (w_a_ext == w_min);
    w_corner = w_div0 | w_ovf;
    if (w_div0) w_corner_val = bus.div_rem ? w_a_ext : '1;
    else        w_corner_val = bus.div_rem ? '0 : w_a_ext;
    w_corner_val = f_wext(bus.div_word, w_corner_val);
    w_accept = bus.div_valid & (r_state == S_IDLE) & ~bus.div_flush;
    w_resp   = r_out_valid & bus.out_ready & (r_state == S_DONE);
  end

  // One restoring step plus the sign-corrected result of that step.
  logic [XLEN:0]   w_shift;
  logic            w_ge, w_last;
  logic [XLEN-1:0] w_sub, w_rem_step, w_quo_step, w_q_fix, w_r_fix, w_norm_val;

  always_comb begin
    w_shift    = {r_rem, r_quo[XLEN-1]};
    w_ge       = (w_shift >= {1'b0, r_dvs});
    w_sub      = w_shift[XLEN-1:0] - r_dvs;
    w_rem_step = w_ge ? w_sub : w_shift[XLEN-1:0];
    w_quo_step = {r_quo[XLEN-2:0], w_ge};
    w_last     = (r_cnt == CNT_W'(1));
    w_q_fix    = r_neg_q ? -w_quo_step : w_quo_step;
    w_r_fix    = r_neg_r ? -w_rem_step : w_rem_step;
    w_norm_val = f_wext(r_word, r_rem_sel ? w_r_fix : w_q_fix);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.div_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = w_corner ? S_DONE : S_BUSY;
        S_BUSY:  if (w_last)   w_state_nxt = S_DONE;
        S_DONE:  if (w_resp)   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath; for corner cases r_quo parks the final value until out_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_word      <= 1'b0;
      r_rem_sel   <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (bus.div_flush) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_word    <= bus.div_word;
          r_rem_sel <= bus.div_rem;
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_dvs     <= w_b_mag;
          r_rem     <= '0;
          r_cnt     <= bus.div_word ? CNT_W'(HALF) : CNT_W'(XLEN);
          if (w_corner)          r_quo <= w_corner_val;
          else if (bus.div_word) r_quo <= {w_a_mag[HALF-1:0], {HALF{1'b0}}};
          else                   r_quo <= w_a_mag;
        end
        S_BUSY: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_result    <= w_norm_val;
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= r_quo;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.div_ready  = (r_state == S_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.div_result = r_result;
endmodule

// File: tb/tb_ysyx_22041461_divider.sv
// Self-checking bench: directed RV64M corner cases, randomized operations against an
// arithmetic reference model, backpressure, flush and asynchronous reset.
module tb_ysyx_22041461_divider;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ysyx_22041461_divider_if bus();

  ysyx_22041461_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Reference: plain RISC-V M-extension semantics using language arithmetic.
  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input logic w, input logic r);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q64, r64;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (s) begin
        q32 = 32'($signed(a32) / $signed(b32));
        r32 = 32'($signed(a32) % $signed(b32));
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q64 = {{32{q32[31]}}, q32};
      r64 = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q64 = '1; r64 = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q64 = a; r64 = 64'd0;
      end else if (s) begin
        q64 = 64'($signed(a) / $signed(b));
        r64 = 64'($signed(a) % $signed(b));
      end else begin
        q64 = a / b; r64 = a % b;
      end
    end
    return r ? r64 : q64;
  endfunction

  function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b,
                                     input logic s, input logic w);
    if (w) begin
      if (b[31:0] == 32'd0) return 1;
      if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 32;
    end
    if (b == 64'd0) return 1;
    if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 64;
  endfunction

  task automatic drive_req(input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic w, input logic r);
    bus.div_valid    = 1'b1;
    bus.div_dividend = a;
    bus.div_divisor  = b;
    bus.div_signed   = s;
    bus.div_word     = w;
    bus.div_rem      = r;
  endtask

  // Called at a negedge with the divider idle; returns at the negedge after the result handshake.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic w, input logic r, input string name);
    logic [63:0] exp;
    int          lat;
    int          n;
    bit          dirty;
    exp   = ref_result(a, b, s, w, r);
    lat   = ref_latency(a, b, s, w);
    dirty = 0;
    checks++;
    if (bus.div_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_issue: got %b want 1", name, bus.div_ready);
    end
    drive_req(a, b, s, w, r);
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
    n = 0;
    do begin
      if (bus.out_valid !== 1'b1 && bus.div_result !== 64'd0) dirty = 1;
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 100);
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want %0d", name, n, lat);
    end
    checks++;
    if (bus.div_result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, bus.div_result, exp);
    end
    checks++;
    if (dirty) begin
      errors++;
      $display("FAIL %s result_zero_while_invalid: got nonzero want 0", name);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.div_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after_handshake: got valid=%b ready=%b want 0/1",
               name, bus.out_valid, bus.div_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.div_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.div_result !== 64'd0) begin
      errors++;
      $display("FAIL %s: got ready=%b valid=%b result=%h want 1/0/0",
               name, bus.div_ready, bus.out_valid, bus.div_result);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.div_valid = 1'b0; bus.div_dividend = '0; bus.div_divisor = '0;
    bus.div_signed = 1'b0; bus.div_word = 1'b0; bus.div_rem = 1'b0;
    bus.div_flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_asserted");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_directed();
    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, "divu_100_7");
    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b1, "remu_100_7");
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, "div_m7_2");
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, "rem_m7_2");
    run_op(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, "divu_by_zero");
    run_op(64'h1234, 64'd0, 1'b1, 1'b0, 1'b1, "rem_by_zero");
    run_op(64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, "divuw_by_zero");
    run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, "div_overflow");
    run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b1, "rem_overflow");
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0, "divw_overflow");
    run_op(64'h1234_5678_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 1'b0, "divuw_upper_ignored");
    run_op(64'hDEAD_BEEF_8000_0007, 64'h0000_0001_0000_0003, 1'b0, 1'b1, 1'b1, "remuw_sext");
  endtask

  function automatic logic [63:0] rand_operand(input int mode);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case (mode)
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'($urandom_range(1, 15));
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'h0000_0000_8000_0000;
      5: v = v >> $urandom_range(1, 62);
      6: v = -(v >> $urandom_range(1, 62));
      default: ;
    endcase
    return v;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 160; i++) begin
      logic [63:0] a, b;
      a = rand_operand(int'($urandom_range(0, 9)));
      b = rand_operand(int'($urandom_range(0, 9)));
      run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    drive_req(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.div_result !== 64'd14) begin
      errors++;
      $display("FAIL bp_result: got %h want %h", bus.div_result, 64'd14);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.div_result !== 64'd14 || bus.div_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b result=%h ready=%b want 1/14/0",
                 k, bus.out_valid, bus.div_result, bus.div_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("bp_release_idle");
  endtask

  task automatic test_flush();
    bit seen;
    drive_req(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.div_flush = 1'b1;
    drive_req(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.div_flush = 1'b0;
    bus.div_valid = 1'b0;
    check_reset_outputs("flush_to_idle");
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_no_result: got out_valid pulse want none");
    end
  endtask

  task automatic test_async_reset();
    drive_req(64'hFFFF_0000_1234_5678, 64'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_mid_busy");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_async_reset");
  endtask

  task automatic test_back_to_back();
    run_op(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, "b2b_first");
    run_op(64'hFFFF_FFFF_FFFF_FC18, 64'd10, 1'b1, 1'b0, 1'b0, "b2b_second");
    run_op(64'd12345, 64'd0, 1'b1, 1'b1, 1'b1, "b2b_third");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
